// File: rtl/lock_code_fsm.sv
// lock_code_fsm: multi-digit code lock with failure counting, timed lockout and optional code re-programming
// Optional feature macro: LOCK_CODE_SET_EN (adds SETCODE state, code becomes writable while unlocked)
// Ports:
//   i_clk, i_rst_n                  clock, synchronous active-low reset
//   i_digit_vld, i_digit            keyed digit pulse and value
//   i_enter_trig, i_clear_trig      submit / discard entry pulses
//   i_lock_trig, i_set_trig         relock-abort / enter code-set mode pulses
//   o_unlocked, o_fail, o_lockout   status (fail is a one-cycle pulse)
//   o_entry_cnt, o_entry_buf        buffered digit count and digits, newest in LSBs
module lock_code_fsm #(
  parameter int DIGITS = 4,
  parameter int DIG_W = 4,
  parameter int MAX_TRIES = 3,
  parameter int LOCKOUT_CYC = 50000000,
  parameter logic [DIGITS*DIG_W-1:0] DEFAULT_CODE = 16'h1234
) (
  input  logic                          i_clk,
  input  logic                          i_rst_n,
  input  logic                          i_digit_vld,
  input  logic [DIG_W-1:0]              i_digit,
  input  logic                          i_enter_trig,
  input  logic                          i_clear_trig,
  input  logic                          i_lock_trig,
  input  logic                          i_set_trig,
  output logic                          o_unlocked,
  output logic                          o_fail,
  output logic                          o_lockout,
  output logic [$clog2(DIGITS+1)-1:0]   o_entry_cnt,
  output logic [DIGITS*DIG_W-1:0]       o_entry_buf
);
  localparam int W = DIGITS * DIG_W;
  localparam int CW = $clog2(DIGITS + 1);
  localparam int FW = $clog2(MAX_TRIES + 1);
  localparam int TW = $clog2(LOCKOUT_CYC + 1);
  typedef enum logic [1:0] {S_LOCKED, S_UNLOCKED, S_LOCKOUT, S_SETCODE} state_t;
  state_t r_state;
  logic [W-1:0] r_buf;
  logic [CW-1:0] r_cnt;
  logic [FW-1:0] r_fail_cnt;
  logic [TW-1:0] r_timer;
  logic r_unlocked, r_fail, r_lockout;
  logic [W-1:0] w_code;
  logic w_full, w_match;
`ifdef LOCK_CODE_SET_EN
  logic [W-1:0] r_code;
  assign w_code = r_code;
`else
  logic w_unused;
  assign w_unused = i_set_trig;
  assign w_code = DEFAULT_CODE;
`endif
  assign w_full = r_cnt == CW'(DIGITS);
  assign w_match = w_full && (r_buf == w_code);
  assign o_unlocked = r_unlocked;
  assign o_fail = r_fail;
  assign o_lockout = r_lockout;
  assign o_entry_cnt = r_cnt;
  assign o_entry_buf = r_buf;
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state <= S_LOCKED;
      r_buf <= '0;
      r_cnt <= '0;
      r_fail_cnt <= '0;
      r_timer <= '0;
      r_unlocked <= 1'b0;
      r_fail <= 1'b0;
      r_lockout <= 1'b0;
`ifdef LOCK_CODE_SET_EN
      r_code <= DEFAULT_CODE;
`endif
    end else begin
      r_fail <= 1'b0;
      case (r_state)
        S_LOCKED: begin
          // lock_trig has no effect here but still outranks the other inputs
          if (!i_lock_trig) begin
            if (i_enter_trig) begin
              r_buf <= '0;
              r_cnt <= '0;
              if (w_match) begin
                r_state <= S_UNLOCKED;
                r_unlocked <= 1'b1;
                r_fail_cnt <= '0;
              end else begin
                r_fail <= 1'b1;
                if (r_fail_cnt == FW'(MAX_TRIES - 1)) begin
                  r_state <= S_LOCKOUT;
                  r_lockout <= 1'b1;
                  r_timer <= TW'(LOCKOUT_CYC - 1);
                  r_fail_cnt <= '0;
                end else begin
                  r_fail_cnt <= r_fail_cnt + FW'(1);
                end
              end
            end else if (i_clear_trig) begin
              r_buf <= '0;
              r_cnt <= '0;
            end else if (i_digit_vld && !w_full) begin
              r_buf <= (r_buf << DIG_W) | W'(i_digit);
              r_cnt <= r_cnt + CW'(1);
            end
          end
        end
        S_UNLOCKED: begin
          if (i_lock_trig) begin
            r_state <= S_LOCKED;
            r_unlocked <= 1'b0;
            r_buf <= '0;
            r_cnt <= '0;
          end else if (!i_enter_trig && i_clear_trig) begin
            r_buf <= '0;
            r_cnt <= '0;
          end
`ifdef LOCK_CODE_SET_EN
          else if (!i_enter_trig && i_set_trig) begin
            r_state <= S_SETCODE;
            r_buf <= '0;
            r_cnt <= '0;
          end
`endif
        end
        S_LOCKOUT: begin
          // timer was loaded with LOCKOUT_CYC-1, so lockout spans LOCKOUT_CYC cycles
          if (r_timer == '0) begin
            r_state <= S_LOCKED;
            r_lockout <= 1'b0;
          end else begin
            r_timer <= r_timer - TW'(1);
          end
        end
`ifdef LOCK_CODE_SET_EN
        S_SETCODE: begin
          if (i_lock_trig) begin
            r_state <= S_LOCKED;
            r_unlocked <= 1'b0;
            r_buf <= '0;
            r_cnt <= '0;
          end else if (i_enter_trig) begin
            r_buf <= '0;
            r_cnt <= '0;
            if (w_full) begin
              r_code <= r_buf;
              r_state <= S_UNLOCKED;
            end else begin
              r_fail <= 1'b1;
            end
          end else if (i_clear_trig) begin
            r_buf <= '0;
            r_cnt <= '0;
          end else if (i_digit_vld && !w_full) begin
            r_buf <= (r_buf << DIG_W) | W'(i_digit);
            r_cnt <= r_cnt + CW'(1);
          end
        end
`endif
        default: begin
          r_state <= S_LOCKED;
          r_unlocked <= 1'b0;
          r_lockout <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_lock_code_fsm.sv
// tb_lock_code_fsm: scoreboard bench for lock_code_fsm against a queue-based lock model
module tb_lock_code_fsm;
  localparam int DIGITS = 4;
  localparam int DIG_W = 4;
  localparam int MAX_TRIES = 3;
  localparam int LOCKOUT_CYC = 8;
  localparam logic [15:0] DEF_CODE = 16'h1234;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic digit_vld = 1'b0;
  logic [3:0] digit = '0;
  logic enter_trig = 1'b0;
  logic clear_trig = 1'b0;
  logic lock_trig = 1'b0;
  logic set_trig = 1'b0;
  logic unlocked, fail, lockout;
  logic [2:0] entry_cnt;
  logic [15:0] entry_buf;
  always #5 clk = ~clk;
  lock_code_fsm #(
    .DIGITS(DIGITS), .DIG_W(DIG_W), .MAX_TRIES(MAX_TRIES),
    .LOCKOUT_CYC(LOCKOUT_CYC), .DEFAULT_CODE(DEF_CODE)
  ) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_digit_vld(digit_vld), .i_digit(digit),
    .i_enter_trig(enter_trig), .i_clear_trig(clear_trig), .i_lock_trig(lock_trig),
    .i_set_trig(set_trig), .o_unlocked(unlocked), .o_fail(fail), .o_lockout(lockout),
    .o_entry_cnt(entry_cnt), .o_entry_buf(entry_buf)
  );
  typedef struct packed {
    logic unl;
    logic fl;
    logic lo;
    logic [2:0] cnt;
    logic [15:0] buff;
  } obs_t;
  obs_t exp_q[$];
  int compared = 0;
  int mismatched = 0;
  // model: mode 0=locked 1=unlocked 2=lockout 3=setting code
  int m_mode = 0;
  int m_entry[$];
  logic [15:0] m_code = DEF_CODE;
  int m_fails = 0;
  int m_remain = 0;
  bit m_fail = 0;
`ifdef LOCK_CODE_SET_EN
  localparam bit SET_EN = 1'b1;
`else
  localparam bit SET_EN = 1'b0;
`endif
  function automatic logic [15:0] entry_val();
    logic [15:0] v = '0;
    foreach (m_entry[i]) v = (v << 4) | (16'(m_entry[i]) & 16'hF);
    return v;
  endfunction
  function automatic void model_step(bit r, bit dv, int d, bit en, bit cl, bit lk, bit st);
    m_fail = 0;
    if (!r) begin
      m_mode = 0; m_entry.delete(); m_code = DEF_CODE; m_fails = 0; m_remain = 0;
      return;
    end
    if (m_mode == 2) begin
      m_remain--;
      if (m_remain == 0) m_mode = 0;
    end else if (m_mode == 0) begin
      if (lk) return;
      if (en) begin
        if (m_entry.size() == DIGITS && entry_val() == m_code) begin
          m_mode = 1; m_fails = 0;
        end else begin
          m_fail = 1; m_fails++;
          if (m_fails == MAX_TRIES) begin m_mode = 2; m_remain = LOCKOUT_CYC; m_fails = 0; end
        end
        m_entry.delete();
      end else if (cl) m_entry.delete();
      else if (dv && m_entry.size() < DIGITS) m_entry.push_back(d);
    end else if (m_mode == 1) begin
      if (lk) begin m_mode = 0; m_entry.delete(); end
      else if (en) return;
      else if (cl) m_entry.delete();
      else if (st && SET_EN) begin m_mode = 3; m_entry.delete(); end
    end else begin
      if (lk) begin m_mode = 0; m_entry.delete(); end
      else if (en) begin
        if (m_entry.size() == DIGITS) begin m_code = entry_val(); m_mode = 1; end
        else m_fail = 1;
        m_entry.delete();
      end else if (cl) m_entry.delete();
      else if (dv && m_entry.size() < DIGITS) m_entry.push_back(d);
    end
  endfunction
  function automatic obs_t model_obs();
    obs_t o;
    o.unl = (m_mode == 1 || m_mode == 3);
    o.fl = m_fail;
    o.lo = (m_mode == 2);
    o.cnt = 3'(m_entry.size());
    o.buff = entry_val();
    return o;
  endfunction
  task automatic step(input bit r, input bit dv, input int d, input bit en, input bit cl, input bit lk, input bit st);
    @(negedge clk);
    #1;
    rst_n = r; digit_vld = dv; digit = 4'(d); enter_trig = en;
    clear_trig = cl; lock_trig = lk; set_trig = st;
    model_step(r, dv, d, en, cl, lk, st);
    exp_q.push_back(model_obs());
  endtask
  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1, 0, 0, 0, 0, 0, 0);
  endtask
  task automatic key(input logic [15:0] v, input int n);
    for (int i = n - 1; i >= 0; i--) step(1, 1, int'((v >> (4 * i)) & 16'hF), 0, 0, 0, 0);
  endtask
  task automatic enter();
    step(1, 0, 0, 1, 0, 0, 0);
  endtask
  initial begin : monitor
    obs_t e, a;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        a = {unlocked, fail, lockout, entry_cnt, entry_buf};
        compared++;
        if (a !== e) begin
          mismatched++;
          $display("FAIL outputs t=%0t got unl=%b fail=%b lockout=%b cnt=%0d buf=%h expected unl=%b fail=%b lockout=%b cnt=%0d buf=%h",
                   $time, a.unl, a.fl, a.lo, a.cnt, a.buff, e.unl, e.fl, e.lo, e.cnt, e.buff);
        end
      end
    end
  end
  initial begin : driver
    int r;
    int nd;
    step(0, 0, 0, 0, 0, 0, 0);
    step(0, 1, 7, 1, 0, 0, 0);
    key(16'h1234, 4); enter(); idle(1);
    step(1, 0, 0, 0, 0, 1, 0); idle(1);
    key(16'h1235, 4); enter(); idle(2);
    step(0, 0, 0, 0, 0, 0, 0);
    key(16'h5555, 4); enter(); key(16'h9, 1); enter(); enter();
    for (int i = 0; i < LOCKOUT_CYC + 2; i++) step(1, 1, i, i[0], 0, 0, 0);
    key(16'h1234, 4); enter(); idle(1);
    step(1, 0, 0, 0, 0, 1, 0);
    key(16'h1234, 4); key(16'h9, 1); idle(1);
    step(1, 0, 0, 0, 1, 0, 0);
    key(16'h12, 2); step(1, 0, 0, 0, 1, 0, 0);
    key(16'h123, 3); enter(); idle(1);
    key(16'h123, 3); step(1, 1, 4, 1, 0, 0, 0); idle(1);
    enter(); enter(); enter(); idle(3);
    step(0, 0, 0, 0, 0, 0, 0); idle(2);
`ifdef LOCK_CODE_SET_EN
    key(16'h1234, 4); enter();
    step(1, 0, 0, 0, 0, 0, 1);
    key(16'h98, 2); enter();
    key(16'h9876, 4); enter(); step(1, 0, 0, 0, 0, 1, 0);
    key(16'h1234, 4); enter(); key(16'h9876, 4); enter(); idle(1);
    step(0, 0, 0, 0, 0, 0, 0);
`endif
    for (int c = 0; c < 4000; c++) begin
      r = int'($urandom_range(0, 99));
      if (m_entry.size() < DIGITS && $urandom_range(0, 9) < 7)
        nd = int'((m_code >> (4 * (DIGITS - 1 - m_entry.size()))) & 16'hF);
      else
        nd = int'($urandom_range(0, 15));
      step(($urandom_range(0, 299) != 0), (r < 75) || ($urandom_range(0, 9) == 0), nd,
           (r >= 75 && r < 87), (r >= 87 && r < 91), (r >= 91 && r < 95),
           (r >= 95) || ($urandom_range(0, 19) == 0));
    end
    idle(2);
    repeat (3) @(negedge clk);
    #2;
    if (exp_q.size() != 0) begin
      mismatched++;
      $display("FAIL drain got %0d pending expected 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
